sram_cfg_tx: RTL
================

SRAM_CFG_TX -- requirements
Module: sram_cfg_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning clk cycles per data_clk half-period (legal 1..255).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge; the only clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle request to send a configuration frame.
REQ-005 SHALL have port cfg_data  input  8  SRAM test data pattern.
REQ-006 SHALL have port cfg_addr_start  input  15  first SRAM address.
REQ-007 SHALL have port cfg_addr_end  input  15  last SRAM address.
REQ-008 SHALL have port data  output  1  serial configuration bit to the SRAM data generator.
REQ-009 SHALL have port data_clk  output  1  generated serial bit clock; the receiver samples data on its rising edge.
REQ-010 SHALL have port rx_reset_n  output  1  active-low reset to the receiver, sampled by it on data_clk rising edges.
REQ-011 SHALL have port busy  output  1  high while a frame is in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse when a frame completes.
REQ-013 SHALL have port frame_count  output  16  number of completed frames.

Function
REQ-014 SHALL implement states IDLE, RST, SHIFT, DONE.
REQ-015 SHALL, in IDLE with start=1 at a clk edge, snapshot {cfg_data, cfg_addr_start, cfg_addr_end} into a 38-bit shift register, enter RST, and set busy=1 from that edge.
REQ-016 SHALL ignore start while busy=1 and in DONE; the snapshot SHALL NOT change mid-frame.
REQ-017 SHALL generate each data_clk period as CLK_DIV clk cycles low followed by CLK_DIV clk cycles high; data_clk SHALL idle low.
REQ-018 SHALL change data and rx_reset_n only on the clk edge where data_clk goes or stays low, so both are stable for CLK_DIV cycles before each data_clk rising edge.
REQ-019 SHALL, in RST, issue exactly 2 data_clk periods with rx_reset_n=0 and data=0, then enter SHIFT.
REQ-020 SHALL, in SHIFT, keep rx_reset_n=1 and issue 39 data_clk periods: periods 0-7 carry cfg_data[7] down to [0], periods 8-22 carry cfg_addr_start[14] down to [0], periods 23-37 carry cfg_addr_end[14] down to [0], and period 38 carries data=0 as the receiver latch clock.
REQ-021 SHALL transmit each field MSB first so that the receiver's shift-up register ends with the original bit order.
REQ-022 SHALL enter DONE on the clk edge ending the high half of SHIFT period 38, with data_clk=0, busy=0, done=1 for exactly one cycle, and frame_count incremented by 1 (mod 2^16); it SHALL then return to IDLE.
REQ-023 SHALL make a frame occupy exactly 82*CLK_DIV clk cycles with busy=1, followed by 1 DONE cycle.
REQ-024 SHALL drive data=0 in IDLE and DONE.

Reset
REQ-025 SHALL, on reset=0 at any time including mid-frame, immediately force state=IDLE, data=0, data_clk=0, rx_reset_n=1, busy=0, done=0, frame_count=0, and clear the shift register and all counters.
REQ-026 SHALL NOT count an aborted frame and SHALL accept start on the first clk edge after reset deassertion.

Structure
REQ-027 SHALL take FRAME_BITS=38, DATA_W=8, ADDR_W=15, RST_PULSES=2, LATCH_PULSES=1 and the state enum from shared package sram_test_pkg, which the receiver side also uses.
REQ-028 SHALL place half-period timing in one sub-module, sram_cfg_tx_bitclk, which outputs a one-cycle tick every CLK_DIV clk cycles while enabled and restarts its count when enabled; the FSM and shift register stay in sram_cfg_tx.

Verification
REQ-029 SHALL check: CLK_DIV=4, start with data=0xA5, start=0x0010, end=0x7FFF; a bench-model receiver (shift on data_clk rising edge, latch on edge 38) -> receiver outputs 0xA5/0x0010/0x7FFF, done after 328 busy cycles, frame_count=1.
REQ-030 SHALL check: CLK_DIV=1, data=0x00, start=0x0000, end=0x0001 -> exactly 41 data_clk rising edges, of which the first 2 have rx_reset_n=0, and the captured end address is 0x0001.
REQ-031 SHALL check: start pulsed again at cycles 5 and 100 of a frame -> both pulses ignored, cfg inputs changed mid-frame have no effect, and exactly one done occurs.
REQ-032 SHALL check: reset asserted during SHIFT period 20 -> all outputs are at reset values in the same cycle, no done pulse, frame_count=0, and the next frame is correct.
REQ-033 SHALL check: back-to-back frames with start asserted in the cycle after done -> a second frame begins with its RST phase and frame_count=2.
REQ-034 SHALL check: data and rx_reset_n never toggle within CLK_DIV cycles before any data_clk rising edge (assertion checked over all scenarios).

Source files
------------

// File: rtl/sram_test_pkg.sv
// Shared definitions for the SRAM test configuration link, used by both the
// transmitter and the receiver side.
package sram_test_pkg;

    localparam int FRAME_BITS   = 38;
    localparam int DATA_W       = 8;
    localparam int ADDR_W       = 15;
    localparam int RST_PULSES   = 2;
    localparam int LATCH_PULSES = 1;
    localparam int SHIFT_PULSES = FRAME_BITS + LATCH_PULSES;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RST   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } cfg_state_e;

    // Frame layout as seen on the wire, MSB first: data, start address, end address.
    function automatic logic [FRAME_BITS-1:0] pack_frame(
        input logic [DATA_W-1:0] d,
        input logic [ADDR_W-1:0] a_start,
        input logic [ADDR_W-1:0] a_end
    );
        return {d, a_start, a_end};
    endfunction

endpackage

// File: rtl/sram_cfg_tx_bitclk.sv
// Half-period timer for the serial bit clock: one-cycle tick every CLK_DIV
// clk cycles while enabled, count restarted whenever disabled.
module sram_cfg_tx_bitclk #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam logic [7:0] LAST_CNT = 8'(CLK_DIV - 1);

    logic [7:0] cnt_r;
    logic       tick_s;

    // Tick on the last cycle of each half period.
    always_comb begin
        tick_s = 1'b0;
        if (enable && (cnt_r == LAST_CNT)) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
    end

    // Half-period cycle counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= 8'd0;
        end else if (!enable || tick_s) begin
            cnt_r <= 8'd0;
        end else begin
            cnt_r <= cnt_r + 8'd1;
        end
    end

    assign tick = tick_s;

endmodule

// File: rtl/sram_cfg_tx.sv
// Serial configuration transmitter: sends a receiver reset, then the 38-bit
// SRAM test setup frame MSB first, then one latch pulse.
module sram_cfg_tx
    import sram_test_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic [ADDR_W-1:0] cfg_addr_start,
    input  logic [ADDR_W-1:0] cfg_addr_end,
    output logic              data,
    output logic              data_clk,
    output logic              rx_reset_n,
    output logic              busy,
    output logic              done,
    output logic [15:0]       frame_count
);

    localparam int         MSB        = FRAME_BITS - 1;
    localparam logic [5:0] RST_LAST   = 6'(RST_PULSES - 1);
    localparam logic [5:0] SHIFT_LAST = 6'(SHIFT_PULSES - 1);

    cfg_state_e            state_r;
    logic [FRAME_BITS-1:0] shift_r;
    logic [5:0]            pcnt_r;
    logic                  data_r;
    logic                  data_clk_r;
    logic                  rx_reset_n_r;
    logic                  busy_r;
    logic                  done_r;
    logic [15:0]           frame_count_r;
    logic                  tick_s;

    sram_cfg_tx_bitclk #(
        .CLK_DIV (CLK_DIV)
    ) u_bitclk (
        .clk    (clk),
        .reset  (reset),
        .enable (busy_r),
        .tick   (tick_s)
    );

    // Frame sequencer: data and rx_reset_n only move on edges that leave
    // data_clk low, giving a full half period of setup before each rise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            shift_r       <= '0;
            pcnt_r        <= 6'd0;
            data_r        <= 1'b0;
            data_clk_r    <= 1'b0;
            rx_reset_n_r  <= 1'b1;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            frame_count_r <= 16'd0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        shift_r      <= pack_frame(cfg_data, cfg_addr_start, cfg_addr_end);
                        state_r      <= ST_RST;
                        busy_r       <= 1'b1;
                        rx_reset_n_r <= 1'b0;
                        data_r       <= 1'b0;
                        data_clk_r   <= 1'b0;
                        pcnt_r       <= 6'd0;
                    end
                end
                ST_RST: begin
                    if (tick_s) begin
                        if (!data_clk_r) begin
                            data_clk_r <= 1'b1;
                        end else begin
                            data_clk_r <= 1'b0;
                            if (pcnt_r == RST_LAST) begin
                                state_r      <= ST_SHIFT;
                                pcnt_r       <= 6'd0;
                                rx_reset_n_r <= 1'b1;
                                data_r       <= shift_r[MSB];
                                shift_r      <= {shift_r[MSB-1:0], 1'b0};
                            end else begin
                                pcnt_r <= pcnt_r + 6'd1;
                            end
                        end
                    end
                end
                ST_SHIFT: begin
                    if (tick_s) begin
                        if (!data_clk_r) begin
                            data_clk_r <= 1'b1;
                        end else begin
                            data_clk_r <= 1'b0;
                            if (pcnt_r == SHIFT_LAST) begin
                                state_r       <= ST_DONE;
                                pcnt_r        <= 6'd0;
                                busy_r        <= 1'b0;
                                done_r        <= 1'b1;
                                data_r        <= 1'b0;
                                frame_count_r <= frame_count_r + 16'd1;
                            end else begin
                                // Zeros shifted in at the bottom make the latch period carry data=0.
                                pcnt_r  <= pcnt_r + 6'd1;
                                data_r  <= shift_r[MSB];
                                shift_r <= {shift_r[MSB-1:0], 1'b0};
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    data_r  <= 1'b0;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    busy_r       <= 1'b0;
                    data_r       <= 1'b0;
                    data_clk_r   <= 1'b0;
                    rx_reset_n_r <= 1'b1;
                end
            endcase
        end
    end

    assign data        = data_r;
    assign data_clk    = data_clk_r;
    assign rx_reset_n  = rx_reset_n_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign frame_count = frame_count_r;

endmodule
